// File: rtl/dac_player_pkg.sv
// Shared constants and playback-mode encoding for the DAC sample player.
package dac_player_pkg;

    localparam logic [7:0] MIDSCALE = 8'h80;

    typedef enum logic {
        STREAM = 1'b0,
        LOOP   = 1'b1
    } mode_e;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchroniser for a slow asynchronous pin, followed by a
// registered one-cycle rising-edge pulse.
module pin_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // NOTE: non-blocking assignments let every stage capture its neighbour's old value, so this is a real shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= SYNC_STAGES'({sync, pin});
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/dac_sample_player.sv
// Byte FIFO fed from slow pins, played to the R2R DAC code bus at a
// divider-controlled rate, either consuming (stream) or rotating (loop).
module dac_sample_player
    import dac_player_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int DIV_W       = 16,
    parameter  int DIV_RESET   = 999,
    parameter  int SYNC_STAGES = 2,
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data_in,
    input  logic          wr_strobe,
    input  logic          div_load,
    input  logic          div_sel,
    input  logic          loop_en,
    input  logic          clr_flags,
    output logic [7:0]    sample_out,
    output logic          sample_stb,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          overflow,
    output logic          underrun
);

    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
    localparam logic [DIV_W-1:0] DIV_INIT   = DIV_W'(DIV_RESET);

    logic             wr_rise, div_rise;
    logic [DIV_W-1:0] reload, div_cnt;
    logic [7:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pending;
    mode_e            mode;
    logic             tick, pop, rotate, commit, push_ok, drop, rot_write, underrun_set;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (wr_strobe),
        .rise (wr_rise)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_div_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (div_load),
        .rise (div_rise)
    );

    // A rotation owns the shared read/write port, so a pending push waits for a free cycle.
    always_comb begin
        mode         = mode_e'(loop_en);
        tick         = (div_cnt == '0);
        pop          = tick && (mode == STREAM) && (count != '0);
        rotate       = tick && (mode == LOOP) && (count != '0);
        underrun_set = tick && (mode == STREAM) && (count == '0);
        commit       = pending && !rotate;
        push_ok      = commit && (count != FULL_COUNT);
        drop         = commit && (count == FULL_COUNT);
        rot_write    = rotate && (count != FULL_COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= DIV_INIT;
            reload  <= DIV_INIT;
        end else begin
            div_cnt <= tick ? reload : div_cnt - DIV_W'(1);
            if (div_rise) begin
                if (div_sel) reload[DIV_W-1:8] <= (DIV_W-8)'(data_in);
                else         reload[7:0]       <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= 1'b0;
            sample_out <= MIDSCALE;
            sample_stb <= 1'b0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (commit)       pending <= 1'b0;
            else if (wr_rise) pending <= 1'b1;

            sample_stb <= pop || rotate;
            if (pop || rotate) begin
                sample_out <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + PW'(1);
            end
            if (push_ok || rotate) wr_ptr <= wr_ptr + PW'(1);

            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (drop)           overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            if (underrun_set)   underrun <= 1'b1;
            else if (clr_flags) underrun <= 1'b0;
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable once the pointers return to 0.
    always_ff @(posedge clk) begin
        if (push_ok)        mem[wr_ptr] <= data_in;
        else if (rot_write) mem[wr_ptr] <= mem[rd_ptr];
    end

    assign fifo_count = count;
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

endmodule

// File: tb/tb_dac_sample_player.sv
// Directed self-checking bench for dac_sample_player: reset, stream, overflow,
// loop rotation, deferred push, divider reload timing and async reset.
module tb_dac_sample_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       wr_strobe = 1'b0, div_load = 1'b0, div_sel = 1'b0;
    logic       loop_en = 1'b0, clr_flags = 1'b0;
    logic [7:0] sample_out;
    logic       sample_stb, fifo_full, fifo_empty, overflow, underrun;
    logic [4:0] fifo_count;

    int n_cmp = 0;
    int n_mis = 0;

    dac_sample_player dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .wr_strobe  (wr_strobe),
        .div_load   (div_load),
        .div_sel    (div_sel),
        .loop_en    (loop_en),
        .clr_flags  (clr_flags),
        .sample_out (sample_out),
        .sample_stb (sample_stb),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All helpers start and end on a falling edge.
    task automatic push(input logic [7:0] b);
        data_in   = b;
        wr_strobe = 1'b1;
        repeat (3) @(negedge clk);
        wr_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load_div(input logic sel, input logic [7:0] b);
        div_sel  = sel;
        data_in  = b;
        div_load = 1'b1;
        repeat (3) @(negedge clk);
        div_load = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_stb(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sample_stb) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_strobe_seen"}, seen, 1);
    endtask

    task automatic measure(input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sample_stb) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic release_and_first_tick(input string tag);
        rst = 1'b0;
        repeat (999) @(negedge clk);
        check({tag, "_underrun_before_tick"}, underrun, 0);
        @(negedge clk);
        check({tag, "_underrun_after_tick"}, underrun, 1);
        check({tag, "_hold_midscale"}, sample_out, 8'h80);
        check({tag, "_no_stb_when_empty"}, sample_stb, 0);
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] v);
        case (v)
            8'h00:   return 8'h7F;
            8'h7F:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        int n;
        logic [7:0] x, e;

        // Reset state and default divider.
        repeat (3) @(negedge clk);
        check("rst_sample_out", sample_out, 8'h80);
        check("rst_empty", fifo_empty, 1);
        check("rst_count", fifo_count, 0);
        check("rst_stb", sample_stb, 0);
        check("rst_flags", {overflow, underrun}, 0);
        release_and_first_tick("boot");

        // Stream three bytes at a 4-cycle period.
        load_div(1'b0, 8'h03);
        load_div(1'b1, 8'h00);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_underrun", underrun, 0);
        push(8'h10);
        push(8'h20);
        push(8'h30);
        check("stream_count3", fifo_count, 3);
        wait_stb("s1", 2000);
        check("s1_value", sample_out, 8'h10);
        check("s1_count", fifo_count, 2);
        @(negedge clk);
        check("stb_one_cycle", sample_stb, 0);
        repeat (3) @(negedge clk);
        check("s2_stb", sample_stb, 1);
        check("s2_value", sample_out, 8'h20);
        repeat (4) @(negedge clk);
        check("s3_value", sample_out, 8'h30);
        check("s3_empty", fifo_empty, 1);
        repeat (4) @(negedge clk);
        check("s4_no_stb", sample_stb, 0);
        check("s4_hold", sample_out, 8'h30);
        check("s4_underrun", underrun, 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("s4_clr", underrun, 0);

        // Fill past capacity under a long period, then drain fast.
        load_div(1'b1, 8'h07);
        load_div(1'b0, 8'hD0);
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_flag", fifo_full, 1);
        check("full_count", fifo_count, 16);
        check("no_overflow_yet", overflow, 0);
        push(8'hAA);
        check("overflow_set", overflow, 1);
        check("overflow_count", fifo_count, 16);
        load_div(1'b1, 8'h00);
        load_div(1'b0, 8'h01);
        for (int i = 0; i < 16; i++) begin
            wait_stb($sformatf("drain%0d", i), 3000);
            check($sformatf("drain%0d_value", i), sample_out, i);
        end
        check("drained_empty", fifo_empty, 1);

        // Loop 00,7F,FF at one sample per clock.
        load_div(1'b1, 8'h07);
        load_div(1'b0, 8'hD0);
        push(8'h00);
        push(8'h7F);
        push(8'hFF);
        check("loop_count3", fifo_count, 3);
        load_div(1'b0, 8'h00);
        load_div(1'b1, 8'h00);
        loop_en = 1'b1;
        wait_stb("loop", 3000);
        check("loop0_value", sample_out, 8'h00);
        e = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e = nxt(e);
            check($sformatf("loop%0d_stb", i), sample_stb, 1);
            check($sformatf("loop%0d_value", i), sample_out, e);
            check($sformatf("loop%0d_count", i), fifo_count, 3);
        end

        // Push whose commit collides with a rotation lands one cycle late.
        load_div(1'b0, 8'h01);
        wait_stb("align", 20);
        @(negedge clk);
        check("align_gap", sample_stb, 0);
        data_in   = 8'h55;
        wr_strobe = 1'b1;
        repeat (5) @(negedge clk);
        check("conflict_tick", sample_stb, 1);
        check("conflict_deferred", fifo_count, 3);
        x = sample_out;
        @(negedge clk);
        check("conflict_commit", fifo_count, 4);
        wr_strobe = 1'b0;
        wait_stb("r1", 10);
        check("r1_value", sample_out, nxt(x));
        wait_stb("r2", 10);
        check("r2_value", sample_out, nxt(nxt(x)));
        wait_stb("r3", 10);
        check("r3_value", sample_out, x);
        wait_stb("r4", 10);
        check("r4_new_byte", sample_out, 8'h55);

        // High-byte divider load mid-period only affects the following period.
        load_div(1'b0, 8'h09);
        wait_stb("div_sync", 20);
        measure(50, n);
        check("period_10", n, 10);
        repeat (3) @(negedge clk);
        div_sel  = 1'b1;
        data_in  = 8'h01;
        div_load = 1'b1;
        measure(50, n);
        check("period_unchanged", n, 7);
        measure(400, n);
        check("period_266", n, 266);
        div_load = 1'b0;

        // Asynchronous reset between clock edges.
        loop_en = 1'b0;
        @(negedge clk);
        check("pre_rst_count", fifo_count, 4);
        check("pre_rst_flags", {overflow, underrun}, 2'b11);
        #20 rst = 1'b1;
        #1;
        check("arst_sample_out", sample_out, 8'h80);
        check("arst_count", fifo_count, 0);
        check("arst_empty_full", {fifo_empty, fifo_full}, 2'b10);
        check("arst_flags", {overflow, underrun}, 0);
        check("arst_stb", sample_stb, 0);
        @(negedge clk);
        release_and_first_tick("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
